main_memory_responder: RTL and testbench

// - Block-granular main-memory model answering the cache controller's mem_req_* initiator port.
// - Accepts one 512-bit block read or write-back per request, answers after a fixed LATENCY,

---
 rtl/main_memory_responder.sv | 116 +++++++++++
 tb/tb_main_memory_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Block-granular main-memory model: one 512-bit read/write-back per request, ready after LATENCY cycles.
// Optional MEM_STATS_EN adds saturating completed-read/write counters.
module main_memory_responder #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_OFFSET     = 4,
  parameter int BLOCK_DATA_WIDTH = 512,
  parameter int MEM_BLOCKS_BITS  = 10,
  parameter int LATENCY          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req_enable,
  input  logic                        mem_req_rw,
  input  logic [WORD_SIZE-1:0]        mem_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_wdata,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_rdata,
  output logic                        mem_req_ready,
  output logic                        mem_busy
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]                 mem_rd_count,
  output logic [15:0]                 mem_wr_count
`endif
);

  localparam int IDX_LO = BLOCK_OFFSET;
  localparam int IDX_HI = BLOCK_OFFSET + MEM_BLOCKS_BITS - 1;
  localparam int DEPTH  = 1 << MEM_BLOCKS_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t                        state;
  logic [7:0]                    cnt;
  logic                          rw_q;
  logic [MEM_BLOCKS_BITS-1:0]    idx_q;
  logic [BLOCK_DATA_WIDTH-1:0]   wdata_q;
  logic [BLOCK_DATA_WIDTH-1:0]   mem [DEPTH];

  logic                          go_respond;
  logic                          cur_rw;
  logic [MEM_BLOCKS_BITS-1:0]    cur_idx;
  logic [BLOCK_DATA_WIDTH-1:0]   cur_wdata;

  // Offset bits and bits above the index alias silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[WORD_SIZE-1:IDX_HI+1], mem_req_addr[IDX_LO-1:0]};

  // With LATENCY=1 the RESPOND-entry edge is the acceptance edge, so the live inputs are used.
  always_comb begin
    go_respond = 1'b0;
    cur_rw     = rw_q;
    cur_idx    = idx_q;
    cur_wdata  = wdata_q;
    if (state == IDLE) begin
      cur_rw     = mem_req_rw;
      cur_idx    = mem_req_addr[IDX_HI:IDX_LO];
      cur_wdata  = mem_req_wdata;
      go_respond = mem_req_enable && (LATENCY == 1);
    end else if (state == BUSY) begin
      go_respond = (cnt == 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && go_respond && cur_rw) mem[cur_idx] <= cur_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rw_q          <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      mem_req_rdata <= '0;
      mem_req_ready <= 1'b0;
      mem_busy      <= 1'b0;
`ifdef MEM_STATS_EN
      mem_rd_count  <= '0;
      mem_wr_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_enable) begin
            rw_q          <= mem_req_rw;
            idx_q         <= mem_req_addr[IDX_HI:IDX_LO];
            wdata_q       <= mem_req_wdata;
            cnt           <= 8'(LATENCY - 1);
            state         <= go_respond ? RESPOND : BUSY;
            mem_req_ready <= go_respond;
            mem_busy      <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (go_respond) begin
            state         <= RESPOND;
            mem_req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          mem_req_ready <= 1'b0;
          mem_busy      <= 1'b0;
        end
      endcase
      if (go_respond && !cur_rw) mem_req_rdata <= mem[cur_idx];
`ifdef MEM_STATS_EN
      if (go_respond && !cur_rw && mem_rd_count != 16'hFFFF) mem_rd_count <= mem_rd_count + 16'd1;
      if (go_respond &&  cur_rw && mem_wr_count != 16'hFFFF) mem_wr_count <= mem_wr_count + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized bench for main_memory_responder against a block-indexed reference memory.
module tb_main_memory_responder;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en, rw_i;
  logic [31:0]  addr_i;
  logic [511:0] wdata_i, rdata;
  logic         ready, busy;
  logic         en1, rw1;
  logic [31:0]  addr1;
  logic [511:0] wdata1, rdata1;
  logic         ready1, busy1;
`ifdef MEM_STATS_EN
  logic [15:0]  rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

  int           n_chk = 0, n_fail = 0;
  int           exp_rd = 0, exp_wr = 0;
  logic [511:0] model [int];
  logic [511:0] last_rd = '0;

  always #5 clk = ~clk;

  main_memory_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req_enable(en), .mem_req_rw(rw_i),
    .mem_req_addr(addr_i), .mem_req_wdata(wdata_i), .mem_req_rdata(rdata),
    .mem_req_ready(ready), .mem_busy(busy)
`ifdef MEM_STATS_EN
    , .mem_rd_count(rd_cnt), .mem_wr_count(wr_cnt)
`endif
  );

  main_memory_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req_enable(en1), .mem_req_rw(rw1),
    .mem_req_addr(addr1), .mem_req_wdata(wdata1), .mem_req_rdata(rdata1),
    .mem_req_ready(ready1), .mem_busy(busy1)
`ifdef MEM_STATS_EN
    , .mem_rd_count(rd_cnt1), .mem_wr_count(wr_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int blk(input logic [31:0] a);
    return int'(a[13:4]);
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input bit rw, input logic [31:0] a, input logic [511:0] wd);
    en = 1'b1; rw_i = rw; addr_i = a; wdata_i = wd;
  endtask

  // Waits out one accepted transaction (acceptance on the next rising edge), optionally scrambling inputs meanwhile.
  task automatic complete(input bit rw, input logic [31:0] a, input logic [511:0] wd, input bit junk);
    int lat = 0;
    @(posedge clk);
    for (int n = 1; n <= LAT + 4; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_after_accept", busy, 1);
      if (ready) begin lat = n; break; end
      if (junk) begin
        en = 1'($urandom); rw_i = 1'($urandom); addr_i = $urandom; wdata_i = rnd512();
      end
    end
    en = 1'b0;
    chk("ready_latency", lat, LAT);
    if (lat != 0) begin
      if (rw) begin
        chk("rdata_held_on_write", rdata, last_rd);
        model[blk(a)] = wd;
        exp_wr++;
      end else begin
        chk("read_data", rdata, model[blk(a)]);
        last_rd = model[blk(a)];
        exp_rd++;
      end
    end
    @(negedge clk);
    chk("ready_single_pulse", ready, 0);
    chk("busy_back_idle", busy, 0);
  endtask

  task automatic txn(input bit rw, input logic [31:0] a, input logic [511:0] wd, input bit junk);
    drive(rw, a, wd);
    complete(rw, a, wd, junk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk_a5, blk_b2b, v1;
    int lat, nrdy;
    blk_a5 = {16{32'hA5A5_0001}};
    en1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    // Reset held with a request pending; nothing may happen until release.
    drive(1'b1, 32'h0000_0080, rnd512());
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_rdata", rdata, '0);
    chk("reset_busy", busy, 0);
    chk("reset_ready_lat1", ready1, 0);
    rst_n = 1'b1;
    complete(1'b1, addr_i, wdata_i, 1'b0);

    txn(1'b1, 32'h0000_0040, blk_a5, 1'b0);
    txn(1'b0, 32'h0000_0040, '0, 1'b0);
    chk("read_0x40", last_rd, blk_a5);
    txn(1'b0, 32'h0000_0047, '0, 1'b0);
    chk("alias_offset", last_rd, blk_a5);
    txn(1'b0, 32'h0000_4040, '0, 1'b0);
    chk("alias_upper", last_rd, blk_a5);

    // Enable held high: write then immediately a read of the same block.
    blk_b2b = rnd512();
    drive(1'b1, 32'h0000_0100, blk_b2b);
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= LAT + 4; n++) begin
      @(negedge clk);
      if (ready) begin lat = n; break; end
    end
    chk("b2b_first_latency", lat, LAT);
    model[blk(32'h100)] = blk_b2b; exp_wr++;
    rw_i = 1'b0;
    lat = 0;
    for (int n = 1; n <= LAT + 6; n++) begin
      @(negedge clk);
      if (ready) begin lat = n; break; end
    end
    en = 1'b0;
    chk("b2b_spacing", lat, LAT + 1);
    chk("b2b_rdata", rdata, blk_b2b);
    last_rd = blk_b2b; exp_rd++;
    @(negedge clk);
    chk("b2b_single_pulse", ready, 0);

    // Reset during a write: no response and the block keeps its old contents.
    drive(1'b1, 32'h0000_0040, rnd512());
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0; last_rd = '0;
    nrdy = 0;
    for (int n = 0; n < LAT + 3; n++) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("no_ready_after_reset", nrdy, 0);
    chk("busy_after_reset", busy, 0);
    chk("rdata_after_reset", rdata, '0);
    txn(1'b0, 32'h0000_0040, '0, 1'b0);
    chk("write_dropped_by_reset", last_rd, blk_a5);

    // LATENCY=1 instance: ready in the cycle right after acceptance, enable drop is harmless.
    v1 = rnd512();
    en1 = 1'b1; rw1 = 1'b1; addr1 = 32'h0000_0200; wdata1 = v1;
    @(posedge clk); #1 en1 = 1'b0;
    @(negedge clk); chk("lat1_wr_ready", ready1, 1);
    @(negedge clk); chk("lat1_wr_pulse", ready1, 0);
    en1 = 1'b1; rw1 = 1'b0;
    @(posedge clk); #1 en1 = 1'b0; rw1 = 1'b1; wdata1 = '0;
    @(negedge clk); chk("lat1_rd_ready", ready1, 1); chk("lat1_rd_data", rdata1, v1);
    @(negedge clk); chk("lat1_rd_pulse", ready1, 0); chk("lat1_busy", busy1, 0);

    // Random traffic with mid-transaction input scrambling.
    repeat (40) begin
      bit rw;
      logic [31:0] a;
      rw = 1'($urandom);
      a = $urandom;
      if (!rw && !model.exists(blk(a))) rw = 1'b1;
      txn(rw, a, rnd512(), 1'b1);
    end

`ifdef MEM_STATS_EN
    chk("stats_rd", rd_cnt, exp_rd);
    chk("stats_wr", wr_cnt, exp_wr);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
